fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of an `AsyncFIFO` between `NUM_REQ` producers in the write clock domain. Each producer is granted whole bursts, bounded by its own `last` flag or by `MAX_BURST` words. The block gates every write on the FIFO's `full_o`, so the FIFO never overflows, and it will not start a new burst while the FIFO reports `almost_full_o`. It sits directly in front of `AsyncFIFO` (`wr_en_i`, `wr_data_i`, `full_o`, `almost_full_o`).

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_priority_picker.sv | 34 +++
 rtl/fifo_write_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_e;

  // Modulo increment that also wraps correctly when n is not a power of two.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] masked;

  always_comb begin
    req_dbl = {req_i, req_i};
    for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
      mask[i] = (i >= 32'(ptr_i));
    end
    masked = req_dbl & mask;
    idx_o  = '0;
    gnt_o  = '0;
    // Scan downward so the lowest masked position wins; the upper copy covers the wrap.
    for (int i = 2 * int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (masked[i]) idx_o = PTR_W'(i % int'(NUM_REQ));
    end
    if (|req_i) gnt_o[idx_o] = 1'b1;
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one AsyncFIFO write port between NUM_REQ producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_almost_full_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BeatW = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PtrW-1:0]    gidx_q, gidx_d;
  logic [PtrW-1:0]    rr_q, rr_d;
  logic [BeatW-1:0]   beat_q, beat_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PtrW-1:0]    pick_idx;
  logic               pick_any;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_picker (
    .req_i (req_valid_i),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    rr_d           = rr_q;
    beat_d         = beat_q;
    req_ready_o    = '0;
    fifo_wr_en_o   = 1'b0;
    fifo_wr_data_o = '0;
    busy_o         = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any && !fifo_almost_full_i) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          beat_d  = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        busy_o         = 1'b1;
        fifo_wr_data_o = req_data_i[32'(gidx_q) * DATA_WIDTH +: DATA_WIDTH];
        // Reset wins over an in-flight transfer so nothing is written in the reset cycle.
        if (!rst_i) begin
          req_ready_o[gidx_q] = !fifo_full_i;
          fifo_wr_en_o        = req_valid_i[gidx_q] & !fifo_full_i;
        end
        if (fifo_wr_en_o) begin
          beat_d = beat_q + BeatW'(1);
          if (req_last_i[gidx_q] || (beat_q == BeatW'(MAX_BURST - 1))) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            rr_d    = PtrW'(rr_next(32'(gidx_q), NUM_REQ));
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed, table-driven bench for fifo_write_arbiter (NUM_REQ=4, MAX_BURST=4).
module tb_fifo_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic            full;
  logic            afull;
  logic [N-1:0]    grant;
  logic            busy;

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req_valid_i        (req_valid),
    .req_data_i         (req_data),
    .req_last_i         (req_last),
    .req_ready_o        (req_ready),
    .fifo_wr_en_o       (wr_en),
    .fifo_wr_data_o     (wr_data),
    .fifo_full_i        (full),
    .fifo_almost_full_i (afull),
    .grant_o            (grant),
    .busy_o             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       full;
    logic       af;
    logic [3:0] g;
    logic [3:0] r;
    logic       w;
    logic       b;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic fl, input logic af,
                     input logic rs, input logic [3:0] g, input logic [3:0] r, input logic w,
                     input logic b);
    vec_t t;
    t.rst = rs; t.v = v; t.l = l; t.full = fl; t.af = af;
    t.g = g; t.r = r; t.w = w; t.b = b;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int step, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
    end
  endtask

  // Data of requester k at step s is {k, s}, so a wrong mux or stale word shows up.
  task automatic drive_data(input int s);
    for (int k = 0; k < int'(N); k++) req_data[k*DW +: DW] = {4'(k), 12'(s)};
  endtask

  initial begin
    logic [15:0] ed;
    rst = 1'b1; req_valid = '0; req_last = '0; full = 1'b0; afull = 1'b0;
    drive_data(0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_grant", -1, 16'(grant), 16'h0);
    chk("reset_busy", -1, 16'(busy), 16'h0);
    chk("reset_ready", -1, 16'(req_ready), 16'h0);
    chk("reset_wr_en", -1, 16'(wr_en), 16'h0);
    chk("reset_data", -1, wr_data, 16'h0);

    //  valid    last     fl af rs grant    ready    w  b
    // Single requester 1, three words, last on the third; rr_ptr moves to 2.
    add(4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 4'b0010, 1, 1);
    add(4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 4'b0010, 1, 1);
    add(4'b0010, 4'b0010, 0, 0, 0, 4'b0010, 4'b0010, 1, 1);
    add(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    // rr_ptr=2 makes requester 2 beat requester 1; req1's last is ignored.
    add(4'b0110, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0110, 4'b0110, 0, 0, 0, 4'b0100, 4'b0100, 1, 1);
    add(4'b0110, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0110, 4'b0010, 0, 0, 0, 4'b0010, 4'b0010, 1, 1);
    // Fairness: all valid, bursts of 3, order 2,3,0,1.
    for (int k = 0; k < 4; k++) begin
      logic [3:0] gk;
      gk = 4'b0001 << ((k + 2) % 4);
      add(4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
      add(4'b1111, 4'b0000, 0, 0, 0, gk, gk, 1, 1);
      add(4'b1111, 4'b0000, 0, 0, 0, gk, gk, 1, 1);
      add(4'b1111, gk,      0, 0, 0, gk, gk, 1, 1);
    end
    // MAX_BURST cap: requester 2 streams 10 words, last only on word 10.
    for (int k = 0; k < 2; k++) begin
      add(4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
      repeat (4) add(4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 4'b0100, 1, 1);
    end
    add(4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 4'b0100, 1, 1);
    add(4'b0100, 4'b0100, 0, 0, 0, 4'b0100, 4'b0100, 1, 1);
    // Full stall for three cycles, then a valid gap, then last.
    add(4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0001, 4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 1, 1);
    repeat (3) add(4'b0001, 4'b0000, 1, 0, 0, 4'b0001, 4'b0000, 0, 1);
    add(4'b0001, 4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 1, 1);
    add(4'b0000, 4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 0, 1);
    add(4'b0001, 4'b0001, 0, 0, 0, 4'b0001, 4'b0001, 1, 1);
    // Almost-full gates new bursts but not a running one.
    add(4'b0100, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0100, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0100, 4'b0000, 0, 1, 0, 4'b0100, 4'b0100, 1, 1);
    add(4'b0100, 4'b0100, 0, 1, 0, 4'b0100, 4'b0100, 1, 1);
    add(4'b0100, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    // Reset mid-burst: no write in reset cycle, rr_ptr back to 0 so req0 beats req3.
    add(4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 4'b1000, 1, 1);
    add(4'b1000, 4'b0000, 0, 0, 0, 4'b1000, 4'b1000, 1, 1);
    add(4'b1000, 4'b0000, 0, 0, 1, 4'b1000, 4'b0000, 0, 1);
    add(4'b1001, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1001, 4'b0001, 0, 0, 0, 4'b0001, 4'b0001, 1, 1);
    add(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req_valid = vecs[i].v; req_last = vecs[i].l;
      full = vecs[i].full; afull = vecs[i].af;
      drive_data(i);
      #1;
      ed = 16'h0;
      for (int k = 0; k < 4; k++) if (vecs[i].g[k]) ed = {4'(k), 12'(i)};
      chk("grant", i, 16'(grant), 16'(vecs[i].g));
      chk("ready", i, 16'(req_ready), 16'(vecs[i].r));
      chk("wr_en", i, 16'(wr_en), 16'(vecs[i].w));
      chk("busy", i, 16'(busy), 16'(vecs[i].b));
      chk("wr_data", i, wr_data, ed);
    end

    // Random traffic: never write into a full FIFO, grant one-hot, ready only to owner.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rst = 1'b0;
      req_valid = 4'($urandom);
      req_last = 4'($urandom);
      full = 1'($urandom_range(0, 1));
      afull = 1'($urandom_range(0, 1));
      drive_data(i);
      #1;
      chk("rand_full_write", i, 16'(wr_en & full), 16'h0);
      chk("rand_grant_onehot", i, 16'($onehot0(grant)), 16'h1);
      chk("rand_ready_owner", i, 16'(req_ready & ~grant), 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
